// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   UART transmit serializer fed directly by the TX uart_fifo. When enabled and
//   the FIFO is non-empty it pops one byte (single-cycle registered rd_en),
//   then shifts out: start bit, DATA_BITS data bits LSB first, optional parity,
//   then one or two stop bits. Each bit lasts baud_div+1 clocks. The divider,
//   parity and stop settings are latched when the byte is loaded, so config
//   writes never disturb a frame already on the line.
//
//   Build option: define UART_TX_PARITY_EN to build the PARITY state. Without
//   it, parity_en/parity_odd are accepted but ignored (8N1 / 8N2 only).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   fifo_empty   TX FIFO empty flag
//   fifo_data    TX FIFO data_out, valid one clock after rd_en is sampled
//   fifo_rd_en   TX FIFO read enable, registered one-clock pulse
//   tx_enable    0 = finish the current frame, then fetch nothing more
//   baud_div     bit period minus one, in clocks
//   parity_en    insert a parity bit
//   parity_odd   1 = odd parity, 0 = even parity
//   stop2        1 = two stop bits, 0 = one
//   tx           serial line, idle high (registered)
//   busy         high in every state except IDLE
//   tx_done      one-clock pulse during the final clock of the last stop bit
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  input  logic                 tx_enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;       // clocks left in the current bit
  logic [DIV_WIDTH-1:0] div_l, div_n;     // divider latched at LOAD
  logic [BW-1:0]        bit_cnt, bit_n;   // data bit index, reused as stop index
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 stop2_l, s2_n;
  logic                 tx_n, rd_n;
  logic                 tick;

`ifdef UART_TX_PARITY_EN
  logic [DATA_BITS-1:0] data_l, data_n;   // unshifted copy for the parity bit
  logic                 pen_l, pen_n;
  logic                 pod_l, pod_n;
`else
  logic                 unused_cfg;
  assign unused_cfg = parity_en ^ parity_odd;
`endif

  // Last clock of the current bit period.
  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_l      <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      stop2_l    <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_l     <= '0;
      pen_l      <= 1'b0;
      pod_l      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      div_l      <= div_n;
      bit_cnt    <= bit_n;
      sh         <= sh_n;
      stop2_l    <= s2_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_n;
`ifdef UART_TX_PARITY_EN
      data_l     <= data_n;
      pen_l      <= pen_n;
      pod_l      <= pod_n;
`endif
    end
  end

  // tx is registered: the value computed at a bit boundary is what the line
  // carries for the whole of the following bit period.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_l;
    bit_n   = bit_cnt;
    sh_n    = sh;
    s2_n    = stop2_l;
    tx_n    = tx;
    rd_n    = 1'b0;
    tx_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    data_n  = data_l;
    pen_n   = pen_l;
    pod_n   = pod_l;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_enable && !fifo_empty) begin
          rd_n    = 1'b1;
          state_n = FETCH;
        end
      end
      // rd_en drops here; FIFO data becomes valid during LOAD.
      FETCH: state_n = LOAD;
      LOAD: begin
        sh_n    = fifo_data;
        div_n   = baud_div;
        cnt_n   = baud_div;
        s2_n    = stop2;
        bit_n   = '0;
        tx_n    = 1'b0;
        state_n = START;
`ifdef UART_TX_PARITY_EN
        data_n  = fifo_data;
        pen_n   = parity_en;
        pod_n   = parity_odd;
`endif
      end
      START: begin
        if (tick) begin
          cnt_n   = div_l;
          tx_n    = sh[0];
          sh_n    = sh >> 1;
          state_n = DATA;
        end else begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n = div_l;
          if (bit_cnt == LAST_BIT) begin
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = STOP;
`ifdef UART_TX_PARITY_EN
            if (pen_l) begin
              tx_n    = (^data_l) ^ pod_l;
              state_n = PARITY;
            end
`endif
          end else begin
            bit_n = bit_cnt + BW'(1);
            tx_n  = sh[0];
            sh_n  = sh >> 1;
          end
        end else begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_n   = div_l;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_n = div_l;
          if (stop2_l && bit_cnt == '0) begin
            bit_n = BW'(1);
          end else begin
            tx_done = 1'b1;
            bit_n   = '0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - DIV_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine with a small behavioural FIFO in front.
//   Expected frames are built from the byte and format settings; the parity
//   bit is expected only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        tx_enable;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        tx;
  logic        busy;
  logic        tx_done;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_engine #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx_enable  (tx_enable),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered data_out, one pop per sampled rd_en.
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  // Event counters, sampled mid-cycle.
  int rd_cnt   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) rd_cnt   <= rd_cnt + 1;
    if (tx_done === 1'b1)    done_cnt <= done_cnt + 1;
    if (busy === 1'b1)       busy_cnt <= busy_cnt + 1;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Counts idle-high clocks until the start bit, then
  // checks every clock of the frame against the expected bit sequence.
  // new_div is driven onto baud_div at the start of data bit 0.
  task automatic check_frame(input string tag, input logic [7:0] d,
                             input bit pen, input bit podd, input bit s2,
                             input int div, input int new_div, output int gap);
    int nb;
    int bad;
    logic [11:0] exp_b;
    logic [11:0] obs_b;
    bit par;
    par   = PAR_BUILT && pen;
    nb    = 10 + (par ? 1 : 0) + (s2 ? 1 : 0);
    exp_b = 12'hFFF;
    obs_b = 12'hFFF;
    exp_b[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_b[i+1] = d[i];
    if (par) exp_b[9] = (^d) ^ podd;
    gap = 0;
    while (tx !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    n_tests++;
    assert (gap < 300) else begin
      n_fail++;
      $error("FAIL %s_start observed no start bit expected start within 300 clks", tag);
    end
    if (gap >= 300) return;
    bad = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k <= div; k++) begin
        if (b == 1 && k == 0) baud_div = new_div[15:0];
        if (k == 0) obs_b[b] = tx;
        if (tx !== exp_b[b]) bad++;
        @(negedge clk);
      end
    end
    n_tests++;
    assert (bad == 0) else begin
      n_fail++;
      $error("FAIL %s_bits observed %h (%0d bad clks) expected %h", tag, obs_b, bad, exp_b);
    end
  endtask

  initial begin
    int gap;
    int r0, d0, b0, lows;
    rst_n      = 1'b0;
    tx_enable  = 1'b1;
    baud_div   = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_tx_done", int'(tx_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // tx_enable low: no fetch even with data waiting
    tx_enable = 1'b0;
    r0 = rd_cnt;
    push(8'h55);
    repeat (10) @(negedge clk);
    chk("gate_rd", rd_cnt - r0, 0);
    chk("gate_busy", int'(busy), 0);

    // 1: 0x55 8N1, 4 clks per bit
    b0 = busy_cnt; d0 = done_cnt; r0 = rd_cnt;
    tx_enable = 1'b1;
    check_frame("t1", 8'h55, 1'b0, 1'b0, 1'b0, 3, 3, gap);
    chk("t1_latency", gap, 3);
    repeat (2) @(negedge clk);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_busy_clks", busy_cnt - b0, 42);
    chk("t1_rd", rd_cnt - r0, 1);

    // 2: 0xA5 with even then odd parity
    parity_en = 1'b1; parity_odd = 1'b0;
    push(8'hA5);
    check_frame("t2_even", 8'hA5, 1'b1, 1'b0, 1'b0, 3, 3, gap);
    parity_odd = 1'b1;
    d0 = done_cnt;
    push(8'hA5);
    check_frame("t2_odd", 8'hA5, 1'b1, 1'b1, 1'b0, 3, 3, gap);
    @(negedge clk);
    chk("t2_done", done_cnt - d0, 1);

    // 3: 0x80, two stop bits, one clk per bit
    parity_odd = 1'b0; stop2 = 1'b1; baud_div = 16'd0;
    r0 = rd_cnt; d0 = done_cnt;
    push(8'h80);
    check_frame("t3", 8'h80, 1'b1, 1'b0, 1'b1, 0, 0, gap);
    repeat (3) @(negedge clk);
    chk("t3_rd", rd_cnt - r0, 1);
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_idle_tx", int'(tx), 1);

    // 4: back-to-back bytes
    parity_en = 1'b0; stop2 = 1'b0; baud_div = 16'd1;
    r0 = rd_cnt;
    push(8'h11);
    push(8'h22);
    check_frame("t4a", 8'h11, 1'b0, 1'b0, 1'b0, 1, 1, gap);
    check_frame("t4b", 8'h22, 1'b0, 1'b0, 1'b0, 1, 1, gap);
    chk("t4_gap", gap, 3);
    repeat (3) @(negedge clk);
    chk("t4_rd", rd_cnt - r0, 2);

    // 6: divider change mid-frame only affects the next frame
    baud_div = 16'd2;
    push(8'h3C);
    push(8'hC3);
    check_frame("t6a", 8'h3C, 1'b0, 1'b0, 1'b0, 2, 9, gap);
    check_frame("t6b", 8'hC3, 1'b0, 1'b0, 1'b0, 9, 9, gap);
    chk("t6_gap", gap, 3);
    repeat (2) @(negedge clk);

    // 5: async reset during data bit 4 of 0x0F (bit 4 is 0)
    baud_div = 16'd3;
    push(8'h0F);
    gap = 0;
    while (tx !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    chk("t5_start_seen", int'(gap < 300), 1);
    repeat (21) @(negedge clk);
    chk("t5_pre_tx", int'(tx), 0);
    chk("t5_pre_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tx", int'(tx), 1);
    chk("t5_async_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_cnt;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("t5_post_rd", rd_cnt - r0, 0);
    chk("t5_post_tx_low_clks", lows, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
